// File: rtl/serial_add2_pkg.sv
// Shared types and helpers for the serial 2-bit-slice adder sequencer.
package serial_add2_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned SLICE_W = 2;

  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned slices;
    slices = width / SLICE_W;
    return (slices <= 2) ? 1 : $clog2(slices);
  endfunction

endpackage

// File: rtl/shift2_reg.sv
// WIDTH-bit register: synchronous clear, parallel load, shift right by one slice with top insert.
module shift2_reg
  import serial_add2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [WIDTH-1:0]   d_i,
  input  logic [SLICE_W-1:0] ins_i,
  output logic [SLICE_W-1:0] lo_o,
  output logic [WIDTH-1:0]   shifted_o
);

  logic [WIDTH-1:0] data_q, data_d, shifted;

  if (WIDTH == SLICE_W) begin : g_narrow
    assign shifted = ins_i;
  end else begin : g_wide
    assign shifted = {ins_i, data_q[WIDTH-1:SLICE_W]};
  end

  always_comb begin
    data_d = data_q;
    if (clr_i)        data_d = '0;
    else if (load_i)  data_d = d_i;
    else if (shift_i) data_d = shifted;
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign lo_o      = data_q[SLICE_W-1:0];
  assign shifted_o = shifted;

endmodule

// File: rtl/serial_add2_ctrl.sv
// Sequencer adding two WIDTH-bit operands through an external 2-bit adder, LSB slice first.
// Optional overflow flag output enabled by defining SERIAL_ADD2_OVF_EN.
module serial_add2_ctrl
  import serial_add2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD2_OVF_EN
  output logic             ovf,
`endif
  output logic             add_a0,
  output logic             add_b0,
  output logic             add_a1,
  output logic             add_b1,
  output logic             add_c0,
  input  logic             add_s0,
  input  logic             add_s1,
  input  logic             add_c2
);

  localparam int unsigned CW   = cnt_width(WIDTH);
  localparam int unsigned LAST = WIDTH / SLICE_W - 1;

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("serial_add2_ctrl: WIDTH must be even and >= 2");
  end

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               accept, run, last;
  logic [SLICE_W-1:0] a_lo, b_lo;
  logic [WIDTH-1:0]   s_next;
  logic [WIDTH-1:0]   unused_a_shift, unused_b_shift;
  logic [SLICE_W-1:0] unused_s_lo;

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign run    = (state_q == RUN);
  assign last   = run && (cnt_q == CW'(LAST));

  shift2_reg #(.WIDTH(WIDTH)) u_a_sh (
    .clk_i(clk), .clr_i(rst), .load_i(accept), .shift_i(run),
    .d_i(a), .ins_i('0), .lo_o(a_lo), .shifted_o(unused_a_shift)
  );

  shift2_reg #(.WIDTH(WIDTH)) u_b_sh (
    .clk_i(clk), .clr_i(rst), .load_i(accept), .shift_i(run),
    .d_i(b), .ins_i('0), .lo_o(b_lo), .shifted_o(unused_b_shift)
  );

  // Sum collector is never loaded; WIDTH/2 shifts fully overwrite any stale content.
  shift2_reg #(.WIDTH(WIDTH)) u_s_sh (
    .clk_i(clk), .clr_i(rst), .load_i(1'b0), .shift_i(run),
    .d_i('0), .ins_i({add_s1, add_s0}), .lo_o(unused_s_lo), .shifted_o(s_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CW'(LAST)) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (run) begin
      carry_q <= add_c2;
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        sum_q  <= s_next;
        cout_q <= add_c2;
      end
    end
  end

`ifdef SERIAL_ADD2_OVF_EN
  logic ovf_q;
  // In the final slice a_lo[1]/b_lo[1] are the operand MSBs and add_s1 is the sum MSB.
  always_ff @(posedge clk) begin
    if (rst)       ovf_q <= 1'b0;
    else if (last) ovf_q <= (a_lo[1] == b_lo[1]) && (add_s1 != a_lo[1]);
  end
  assign ovf = ovf_q;
`endif

  always_comb begin
    add_a0 = 1'b0;
    add_a1 = 1'b0;
    add_b0 = 1'b0;
    add_b1 = 1'b0;
    add_c0 = 1'b0;
    if (run) begin
      add_a0 = a_lo[0];
      add_a1 = a_lo[1];
      add_b0 = b_lo[0];
      add_b1 = b_lo[1];
      add_c0 = carry_q;
    end
  end

  assign busy = run;
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_add2_ctrl.md
Name: serial_add2_ctrl

Overview:
Multi-cycle sequencer that adds two WIDTH-bit operands using the existing combinational 2-bit adder stage (a0,b0,a1,b1,c0 -> s0,s1,c2) as its datapath.
- Upstream side: slices the operands 2 bits per cycle, LSB pair first, and drives the 2-bit adder inputs.
- Downstream side: captures the adder's sum and carry outputs, chains the carry through a register, and assembles the full result.
- Sits between a register-file/operand source and any result consumer; the adder itself stays external.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2 (elaboration error otherwise)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse in DONE
sum  output  WIDTH  result, valid from done until next accepted start
cout  output  1  final carry, same validity as sum
add_a0, add_b0, add_a1, add_b1, add_c0  output  1 each  drive the 2-bit adder inputs
add_s0, add_s1, add_c2  input  1 each  2-bit adder outputs

Interface note: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry register and counter cleared.
  - Reset overrides everything, including mid-RUN; a partial result is discarded.
- FSM states: IDLE, RUN, DONE. Encoding comes from the package enum.
- IDLE:
  - start=1 -> capture a, b into shift registers and cin into the carry register; cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (WIDTH/2 cycles):
  - Combinational adder drive: add_a0=A_sh[0], add_a1=A_sh[1], add_b0=B_sh[0], add_b1=B_sh[1], add_c0=carry_reg.
  - At each edge:
    - S_sh <= {add_s1, add_s0, S_sh[WIDTH-1:2]}.
    - A_sh, B_sh shift right by 2.
    - carry_reg <= add_c2; cnt++.
  - When cnt == WIDTH/2-1 at the edge: sum <= final S_sh value, cout <= add_c2, go to DONE.
  - start is ignored in RUN; operand inputs are ignored after capture.
- DONE:
  - done=1 for exactly this cycle; sum and cout are held.
  - start=1 here is accepted exactly as in IDLE: new capture, go to RUN (back-to-back operation). Otherwise go to IDLE.
- Adder drive outside RUN: all add_* outputs are 0.
- Latency: start sampled at edge k -> done high during the cycle after edge k+WIDTH/2, i.e. WIDTH/2+1 clocks. WIDTH=8 gives 4 RUN cycles.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1), so no information is lost.
- Between operations, sum and cout keep their last result. They change only at the final RUN edge or on reset.

Optional Feature:
Macro: SERIAL_ADD2_OVF_EN
- Defined:
  - Extra output port ovf (1 bit) = two's-complement overflow of the last operation, computed as (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]) using the captured operands.
  - Registered together with sum, same validity; reset value 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package serial_add2_pkg:
  - typedef enum state_t {IDLE, RUN, DONE}.
  - Constant for the slice width (2).
  - Function computing the counter width $clog2(WIDTH/2) (minimum 1).
- The 2-bit adder remains a separate, external instance; the bench instantiates it and connects it to the add_* ports.
- One natural sub-module: shift2_reg, a WIDTH-bit register with synchronous clear, parallel load and shift-right-by-2 with a 2-bit top insert. It is reused three times (A, B, S).

Test Plan:
1. WIDTH=8; a=0x5A, b=0x3C, cin=0, start 1 cycle -> busy high 4 cycles, done pulse on the 5th clock, sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1 (carry-in chains through all slices).
3. start held high continuously with a=0x01, b=0x02 -> re-accepted in each DONE cycle, done pulses every 5 clocks, sum=0x03. Changing a/b mid-RUN has no effect on the current result.
4. rst asserted on the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0x00, cout=0, state IDLE. A following start runs a full, correct operation.
5. Randomised/exhaustive WIDTH=4 sweep of a, b, cin against a behavioural {cout,sum} -> all 512 cases match; add_* outputs are all 0 whenever busy=0.
6. With SERIAL_ADD2_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1. a=0x80, b=0xFF -> sum=0x7F, cout=1, ovf=1. a=0x10, b=0x20 -> ovf=0.
